// File: rtl/dma_timing_ctrl_pkg.sv
// Shared types for the 8237-style DMA transfer timing controller:
// one-hot state encoding, mode/transfer enums and the DACK decode helper.
package dma_timing_ctrl_pkg;

   localparam int NUM_CH  = 4;
   localparam int STATE_W = 6;

   // One-hot encoding; 6'b010000 (S3) is reserved and never entered.
   typedef enum logic [STATE_W-1:0] {
      ST_SI = 6'b000001,
      ST_SO = 6'b000010,
      ST_S1 = 6'b000100,
      ST_S2 = 6'b001000,
      ST_S4 = 6'b100000
   } state_t;

   typedef enum logic [1:0] {
      MODE_DEMAND  = 2'b00,
      MODE_SINGLE  = 2'b01,
      MODE_BLOCK   = 2'b10,
      MODE_CASCADE = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      XFER_VERIFY     = 2'b00,
      XFER_WRITE      = 2'b01,
      XFER_READ       = 2'b10,
      XFER_VERIFY_ALT = 2'b11
   } xfer_t;

   function automatic logic [NUM_CH-1:0] dack_onehot(input logic [1:0] ch);
      logic [NUM_CH-1:0] v;
      v     = {NUM_CH{1'b0}};
      v[ch] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/dma_timing_ctrl_if.sv
// Bus bundle between the DMA timing controller (master modport) and its
// surroundings: priority logic, datapath and the system bus pins.
interface dma_timing_ctrl_if;
   import dma_timing_ctrl_pkg::*;

   logic               reqValid;
   logic [1:0]         reqChannel;
   logic               dreqActive;
   logic               programCond;
   logic               ctrlDisable;
   logic [1:0]         modeSelect;
   logic [1:0]         transferType;
   logic               terminalCount;
   logic               HLDA;
   logic               EOP_N_in;
   logic               HRQ;
   logic               AEN;
   logic               ADSTB;
   logic [NUM_CH-1:0]  DACK;
   logic               IOR_N;
   logic               IOW_N;
   logic               MEMR_N;
   logic               MEMW_N;
   logic               EOP_N_out;
   logic               updateAddrCnt;
   logic [STATE_W-1:0] state;

   modport master (
      input  reqValid, reqChannel, dreqActive, programCond, ctrlDisable,
             modeSelect, transferType, terminalCount, HLDA, EOP_N_in,
      output HRQ, AEN, ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N,
             EOP_N_out, updateAddrCnt, state
   );

   modport slave (
      output reqValid, reqChannel, dreqActive, programCond, ctrlDisable,
             modeSelect, transferType, terminalCount, HLDA, EOP_N_in,
      input  HRQ, AEN, ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N,
             EOP_N_out, updateAddrCnt, state
   );

endinterface

// File: rtl/dma_timing_ctrl_strobe_gen.sv
// Read/write strobe decode from transfer state and type.
// DMA_EXTENDED_WRITE_EN: write strobe is also asserted in S2 (extended write).
module dma_timing_ctrl_strobe_gen
   import dma_timing_ctrl_pkg::*;
(
   input  state_t state,
   input  xfer_t  xfer,
   output logic   ior_n,
   output logic   iow_n,
   output logic   memr_n,
   output logic   memw_n
);

   logic rd_phase_s;
   logic wr_phase_s;

   // Strobe decode; verify transfers keep every strobe released.
   always_comb begin
      rd_phase_s = (state == ST_S2) || (state == ST_S4);
`ifdef DMA_EXTENDED_WRITE_EN
      wr_phase_s = rd_phase_s;
`else
      wr_phase_s = (state == ST_S4);
`endif
      ior_n  = 1'b1;
      iow_n  = 1'b1;
      memr_n = 1'b1;
      memw_n = 1'b1;
      case (xfer)
         XFER_READ: begin
            memr_n = ~rd_phase_s;
            iow_n  = ~wr_phase_s;
         end
         XFER_WRITE: begin
            ior_n  = ~rd_phase_s;
            memw_n = ~wr_phase_s;
         end
         default: begin
            ior_n  = 1'b1;
            memw_n = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dma_timing_ctrl.sv
// Transfer timing FSM of a 4-channel 8237-style DMA controller.
// Optional macro: DMA_EXTENDED_WRITE_EN (write strobe also in S2).
module dma_timing_ctrl
   import dma_timing_ctrl_pkg::*;
(
   input logic              CLK,
   input logic              RESET_N,
   dma_timing_ctrl_if.master bus
);

   state_t            state_r, state_next_s;
   logic [1:0]        ch_r, ch_next_s;
   mode_t             mode_r, mode_next_s;
   xfer_t             xfer_r, xfer_next_s;
   logic              tc_r, tc_next_s;
   logic              start_s;
   logic              abort_s;
   logic              active_next_s;
   logic              ior_n_s, iow_n_s, memr_n_s, memw_n_s;

   logic              hrq_r, aen_r, adstb_r;
   logic [NUM_CH-1:0] dack_r;
   logic              ior_n_r, iow_n_r, memr_n_r, memw_n_r;
   logic              eop_n_r, update_r;

   // Next-state and field-latch logic; cascade is serviced like single mode.
   always_comb begin
      state_next_s = state_r;
      ch_next_s    = ch_r;
      mode_next_s  = mode_r;
      xfer_next_s  = xfer_r;
      tc_next_s    = tc_r;
      start_s      = bus.reqValid & ~bus.programCond & ~bus.ctrlDisable;
      abort_s      = ~bus.EOP_N_in | ~bus.HLDA;
      case (state_r)
         ST_SI: begin
            if (start_s) begin
               state_next_s = ST_SO;
               ch_next_s    = bus.reqChannel;
               xfer_next_s  = xfer_t'(bus.transferType);
               if (mode_t'(bus.modeSelect) == MODE_CASCADE) begin
                  mode_next_s = MODE_SINGLE;
               end else begin
                  mode_next_s = mode_t'(bus.modeSelect);
               end
            end else begin
               state_next_s = ST_SI;
            end
         end
         ST_SO: begin
            if (!bus.reqValid || !bus.EOP_N_in) begin
               state_next_s = ST_SI;
            end else if (bus.HLDA) begin
               state_next_s = ST_S1;
            end else begin
               state_next_s = ST_SO;
            end
         end
         ST_S1: begin
            if (abort_s) begin
               state_next_s = ST_SI;
            end else begin
               state_next_s = ST_S2;
            end
         end
         ST_S2: begin
            // Word count is stable until the S4 update, so TC is captured here.
            if (abort_s) begin
               state_next_s = ST_SI;
            end else begin
               state_next_s = ST_S4;
               tc_next_s    = bus.terminalCount;
            end
         end
         ST_S4: begin
            if (tc_r || !bus.EOP_N_in) begin
               state_next_s = ST_SI;
            end else begin
               case (mode_r)
                  MODE_BLOCK:  state_next_s = ST_S1;
                  MODE_DEMAND: state_next_s = bus.dreqActive ? ST_S1 : ST_SI;
                  default:     state_next_s = ST_SI;
               endcase
            end
         end
         default: begin
            state_next_s = ST_SI;
         end
      endcase
   end

   // Transfer-phase qualifier for the registered pin decode.
   always_comb begin
      active_next_s = (state_next_s == ST_S1) || (state_next_s == ST_S2) ||
                      (state_next_s == ST_S4);
   end

   dma_timing_ctrl_strobe_gen u_strobe_gen (
      .state  (state_next_s),
      .xfer   (xfer_next_s),
      .ior_n  (ior_n_s),
      .iow_n  (iow_n_s),
      .memr_n (memr_n_s),
      .memw_n (memw_n_s)
   );

   // State, latched fields and pins registered together from the next-state decode.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r  <= ST_SI;
         ch_r     <= 2'b00;
         mode_r   <= MODE_DEMAND;
         xfer_r   <= XFER_VERIFY;
         tc_r     <= 1'b0;
         hrq_r    <= 1'b0;
         aen_r    <= 1'b0;
         adstb_r  <= 1'b0;
         dack_r   <= {NUM_CH{1'b0}};
         ior_n_r  <= 1'b1;
         iow_n_r  <= 1'b1;
         memr_n_r <= 1'b1;
         memw_n_r <= 1'b1;
         eop_n_r  <= 1'b1;
         update_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         ch_r     <= ch_next_s;
         mode_r   <= mode_next_s;
         xfer_r   <= xfer_next_s;
         tc_r     <= tc_next_s;
         hrq_r    <= (state_next_s != ST_SI);
         aen_r    <= active_next_s;
         adstb_r  <= (state_next_s == ST_S1);
         dack_r   <= active_next_s ? dack_onehot(ch_next_s) : {NUM_CH{1'b0}};
         ior_n_r  <= ior_n_s;
         iow_n_r  <= iow_n_s;
         memr_n_r <= memr_n_s;
         memw_n_r <= memw_n_s;
         eop_n_r  <= ~((state_next_s == ST_S4) && tc_next_s);
         update_r <= (state_next_s == ST_S4);
      end
   end

   assign bus.HRQ           = hrq_r;
   assign bus.AEN           = aen_r;
   assign bus.ADSTB         = adstb_r;
   assign bus.DACK          = dack_r;
   assign bus.IOR_N         = ior_n_r;
   assign bus.IOW_N         = iow_n_r;
   assign bus.MEMR_N        = memr_n_r;
   assign bus.MEMW_N        = memw_n_r;
   assign bus.EOP_N_out     = eop_n_r;
   assign bus.updateAddrCnt = update_r;
   assign bus.state         = state_r;

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Self-checking bench for dma_timing_ctrl: scripted and random DMA services,
// expected pins derived from the per-cycle service phase sequence.
module tb_dma_timing_ctrl;

   localparam logic [5:0] SI_C = 6'b000001;
   localparam logic [5:0] SO_C = 6'b000010;
   localparam logic [5:0] S1_C = 6'b000100;
   localparam logic [5:0] S2_C = 6'b001000;
   localparam logic [5:0] S4_C = 6'b100000;

   typedef struct packed {
      logic       req, hlda, eop_n, tc, dreq, prog, dis;
      logic [1:0] ch_in, mode_in, xfer_in;
      logic [5:0] ph;
      logic [1:0] ch, xfer;
      logic       eop_out;
   } step_t;

   logic CLK = 1'b0;
   logic RESET_N;
   dma_timing_ctrl_if bus();

   dma_timing_ctrl dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

   always #5 CLK = ~CLK;

   step_t      plan[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         step_no  = 0;
   logic [1:0] cur_ch, cur_mode, cur_xfer;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Pin vector a correct controller shows in a given phase of a service.
   function automatic logic [15:0] exp_pins(input logic [5:0] ph, input logic [1:0] ch,
                                            input logic [1:0] xfer, input logic eop_out);
      logic       act, rd, wr;
      logic [3:0] one, dack;
      act = (ph == S1_C) || (ph == S2_C) || (ph == S4_C);
      rd  = (ph == S2_C) || (ph == S4_C);
`ifdef DMA_EXTENDED_WRITE_EN
      wr  = rd;
`else
      wr  = (ph == S4_C);
`endif
      one  = 4'b0001;
      dack = act ? (one << ch) : 4'b0000;
      return {3'b000, ph != SI_C, act, ph == S1_C, dack,
              !(xfer == 2'b01 && rd), !(xfer == 2'b10 && wr),
              !(xfer == 2'b10 && rd), !(xfer == 2'b01 && wr),
              eop_out, ph == S4_C};
   endfunction

   function automatic logic [15:0] obs_pins();
      return {3'b000, bus.HRQ, bus.AEN, bus.ADSTB, bus.DACK, bus.IOR_N, bus.IOW_N,
              bus.MEMR_N, bus.MEMW_N, bus.EOP_N_out, bus.updateAddrCnt};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s step %0d: got %h expected %h", tag, step_no, obs, exp);
   endtask

   task automatic push(input logic [5:0] ph, input logic req, input logic hlda,
                       input logic eop_n, input logic tc, input logic dreq,
                       input logic eop_out, input logic prog = 1'b0,
                       input logic dis = 1'b0, input logic entry = 1'b0);
      step_t s;
      s.req = req; s.hlda = hlda; s.eop_n = eop_n; s.tc = tc; s.dreq = dreq;
      s.prog = prog; s.dis = dis; s.ph = ph; s.eop_out = eop_out;
      s.ch = cur_ch; s.xfer = cur_xfer;
      s.ch_in   = entry ? cur_ch   : 2'($urandom_range(0, 3));
      s.mode_in = entry ? cur_mode : 2'($urandom_range(0, 3));
      s.xfer_in = entry ? cur_xfer : 2'($urandom_range(0, 3));
      plan.push_back(s);
   endtask

   // One service: w cycles in SO, n transfers, ended by mode rule/TC or by end_kind:
   // 1 EOP in S4, 2 EOP in S1, 3 EOP in S2, 4 HLDA low in S1, 5 HLDA low in S2.
   task automatic build_service(input logic [1:0] ch, input logic [1:0] mode,
                                input logic [1:0] xfer, input int w, input int n,
                                input int end_kind);
      logic [1:0] em;
      int         nn;
      logic       last, tc_t, dreq_t, eop_s4;
      em = (mode == 2'b11) ? 2'b01 : mode;
      nn = (em == 2'b01) ? 1 : n;
      cur_ch = ch; cur_mode = mode; cur_xfer = xfer;
      push(SO_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i < w; i++) push(SO_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(S1_C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int t = 0; t < nn; t++) begin
         last = (t == nn - 1);
         tc_t = last && ((em == 2'b10 && end_kind == 0) ? 1'b1 : rb());
         if (last && end_kind == 2) begin push(SI_C, rb(), 1'b1, 1'b0, tc_t, 1'b0, 1'b1); break; end
         if (last && end_kind == 4) begin push(SI_C, rb(), 1'b0, 1'b1, tc_t, 1'b0, 1'b1); break; end
         push(S2_C, rb(), 1'b1, 1'b1, tc_t, 1'b0, 1'b1);
         if (last && end_kind == 3) begin push(SI_C, rb(), 1'b1, 1'b0, tc_t, 1'b0, 1'b1); break; end
         if (last && end_kind == 5) begin push(SI_C, rb(), 1'b0, 1'b1, tc_t, 1'b0, 1'b1); break; end
         push(S4_C, rb(), 1'b1, 1'b1, tc_t, 1'b0, !tc_t);
         eop_s4 = !(last && end_kind == 1);
         dreq_t = (em == 2'b00) ? !last : rb();
         push(last ? SI_C : S1_C, rb(), rb(), eop_s4, tc_t, dreq_t, 1'b1);
      end
      push(SI_C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic play_n(input int k);
      step_t s;
      for (int i = 0; i < k && plan.size() > 0; i++) begin
         s = plan.pop_front();
         bus.reqValid = s.req;   bus.HLDA = s.hlda;          bus.EOP_N_in = s.eop_n;
         bus.terminalCount = s.tc; bus.dreqActive = s.dreq;
         bus.programCond = s.prog; bus.ctrlDisable = s.dis;
         bus.reqChannel = s.ch_in; bus.modeSelect = s.mode_in; bus.transferType = s.xfer_in;
         @(posedge CLK);
         #2;
         step_no = step_no + 1;
         check("state", {10'd0, bus.state}, {10'd0, s.ph});
         check("pins", obs_pins(), exp_pins(s.ph, s.ch, s.xfer, s.eop_out));
      end
   endtask

   task automatic play();
      play_n(plan.size());
   endtask

   task automatic idle_inputs();
      bus.reqValid = 1'b0; bus.reqChannel = 2'b00; bus.dreqActive = 1'b0;
      bus.programCond = 1'b0; bus.ctrlDisable = 1'b0; bus.modeSelect = 2'b00;
      bus.transferType = 2'b00; bus.terminalCount = 1'b0; bus.HLDA = 1'b0;
      bus.EOP_N_in = 1'b1;
   endtask

   initial begin
      RESET_N = 1'b0;
      idle_inputs();
      cur_ch = 2'b00; cur_mode = 2'b00; cur_xfer = 2'b00;
      repeat (2) @(posedge CLK);
      #2;
      check("rst_state", {10'd0, bus.state}, {10'd0, SI_C});
      check("rst_pins", obs_pins(), exp_pins(SI_C, 2'b00, 2'b00, 1'b1));
      RESET_N = 1'b1;
      push(SI_C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      play();

      build_service(2'd2, 2'b01, 2'b10, 3, 1, 0); play();   // single read ch2
      build_service(2'd1, 2'b10, 2'b01, 1, 3, 0); play();   // block write, TC on 3rd
      build_service(2'd3, 2'b00, 2'b01, 2, 2, 0); play();   // demand, DREQ drops
      build_service(2'd0, 2'b01, 2'b10, 1, 1, 3); play();   // EOP in S2
      build_service(2'd0, 2'b01, 2'b01, 1, 1, 1); play();   // EOP in S4
      build_service(2'd2, 2'b10, 2'b10, 2, 3, 4); play();   // HLDA lost in S1
      build_service(2'd1, 2'b11, 2'b10, 1, 2, 0); play();   // cascade as single
      build_service(2'd3, 2'b10, 2'b00, 1, 2, 0); play();   // block verify

      // programCond / ctrlDisable hold SI; SO exits on reqValid drop and on EOP
      cur_ch = 2'd1; cur_mode = 2'b01; cur_xfer = 2'b10;
      push(SI_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      push(SI_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      push(SI_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      push(SO_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(SO_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(SI_C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(SO_C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      push(SI_C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      push(SI_C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      play();

      // Asynchronous reset while in S2 of a read (MEMR_N low)
      build_service(2'd2, 2'b01, 2'b10, 2, 1, 0);
      play_n(4);
      #1 RESET_N = 1'b0;
      #1;
      check("rst_mid_state", {10'd0, bus.state}, {10'd0, SI_C});
      check("rst_mid_pins", obs_pins(), exp_pins(SI_C, 2'b00, 2'b00, 1'b1));
      plan.delete();
      idle_inputs();
      @(posedge CLK);
      #2;
      check("rst_hold_pins", obs_pins(), exp_pins(SI_C, 2'b00, 2'b00, 1'b1));
      RESET_N = 1'b1;
      push(SI_C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      play();

      for (int r = 0; r < 40; r++) begin
         build_service(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                       int'($urandom_range(1, 4)),
                       ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 5)));
         play();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
